rtr_out_alloc: RTL and testbench
================================

# rtr_out_alloc

Per-output switch allocator and output-port controller for the NoC router. It shares one router output among IN_PORTS input units, grants one flit per cycle with round-robin fairness, and holds the output for the owning input from head to tail (wormhole lock). It tracks downstream buffer space with a credit counter and drives a registered output channel. Its `avail_out`/`ready_out` feed the per-input `avail_outps`/`ready_outps` bits; its `grant_out` feeds each input's `sa_grant`.

## Interface
- `IN_PORTS`, default 4: number of requesting inputs (≥1).
- `FLIT_WIDTH`, default 16: flit width; `data[1:0]` is the flit type, decoded with `flit_is_head`/`flit_is_tail`/`flit_is_single` from `axi4_duth_noc_pkg`.
- `BUF_DEPTH`, default 4: downstream buffer slots, which is also the initial credit count (≥1).
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_in` input IN_PORTS: per-input request for this output.
- `data_in` input IN_PORTS*FLIT_WIDTH: flit of input i at `[i*FLIT_WIDTH +: FLIT_WIDTH]`.
- `grant_out` output IN_PORTS: one-hot or zero grant, combinational, same cycle as the request.
- `avail_out` output 1: output not locked to any packet.
- `ready_out` output 1: credit count is non-zero.
- `valid_out` output 1: registered flit valid toward the link.
- `data_out` output FLIT_WIDTH: registered flit.
- `credit_in` input 1: one downstream slot freed, one pulse per slot.

## Operation
- **State:** `lock_r`, `owner_r[clog2(IN_PORTS)]`, `ptr_r[clog2(IN_PORTS)]` (round-robin priority), `cred_r[clog2(BUF_DEPTH+1)]`, output register.
- **Eligible set:**
  - When `lock_r`=1: `req_in & onehot(owner_r)`.
  - Otherwise: `req_in`.
  - The set is masked to zero when `cred_r`==0.
  - The allocator masks internally; it does not rely on the inputs gating their requests.
- **Arbitration:** round-robin. The first eligible index scanning `ptr_r`, `ptr_r`+1, … modulo IN_PORTS wins. `grant_out` = onehot(winner), or 0 if no input is eligible.
- **On any grant (winner w, flit f = data_in[w]):**
  - `ptr_r` ← (w+1) mod IN_PORTS.
  - `cred_r` decrements.
  - Output register loads `valid_out`=1 and `data_out`=f.
  - If f is a head flit (not single): `lock_r`←1, `owner_r`←w.
  - If f is a tail or single flit: `lock_r`←0.
  - If f is a body flit: lock state is unchanged.
- **No grant:** `valid_out`←0; `data_out` holds its previous value.
- **Lock states:**
  - FREE (`lock_r`=0) → LOCKED on a head grant.
  - LOCKED → FREE on a tail grant from the owner.
  - A single flit granted in FREE stays in FREE.
- **Outputs:** `avail_out` = !`lock_r`; `ready_out` = (`cred_r`!=0).
- **Credits:**
  - grant without `credit_in`: `cred_r`−1.
  - `credit_in` without grant: `cred_r`+1.
  - both in the same cycle: unchanged.
  - `cred_r` never exceeds BUF_DEPTH. An assertion fires (`$fatal`) if `credit_in` arrives while `cred_r`==BUF_DEPTH with no grant in that cycle.
- **Request hold:** inputs may drop requests at any time. A locked owner that drops its request stalls the output; no other input is granted.
- **Assertions:**
  - `grant_out` is one-hot or zero.
  - No grant when `cred_r`==0.
  - Every granted flit has no X in `data[1:0]`.

## Timing
- **Reset** (`rst_n`=0, asynchronous): `lock_r`=0, `owner_r`=0, `ptr_r`=0, `cred_r`=BUF_DEPTH, `valid_out`=0, `data_out`=0. Consequently `avail_out`=1 and `ready_out`=1 (BUF_DEPTH≥1), and `grant_out` is 0 while reset is held.
- **Latency:** request → grant in 0 cycles (combinational). Grant → `valid_out`/`data_out` in 1 cycle. Throughput is one flit per cycle while credits remain.
- **Status outputs:** `avail_out` and `ready_out` reflect registered state only; there is no combinational path from `req_in` or `credit_in`.
- **Credit return:** a `credit_in` at edge t allows a grant in cycle t+1 when `cred_r` was 0.
- **Reset mid-packet:** clears the lock and credits as above. Upstream and downstream are reset together, so no flush is required.

## Test plan
- **Single flit:** IN_PORTS=4, reset, `req_in`=0010 with a SINGLE flit → `grant_out`=0010 the same cycle; next cycle `valid_out`=1 and `data_out` equals the flit; `cred_r`=3; `ptr_r`=2; `avail_out` stays 1.
- **Round-robin:** `req_in`=1111 held with SINGLE flits for 4 cycles from reset → grants 0001, 0010, 0100, 1000; 4 flits out; `ready_out`=0 afterwards and no grant until `credit_in`.
- **Wormhole lock:** input 0 sends HEAD, BODY, TAIL while input 3 requests continuously → grants 0001 ×3; `avail_out`=0 in the two cycles after the HEAD grant; the cycle after the TAIL grant, input 3 is granted and `avail_out`=1.
- **Owner stall:** lock held by input 1, `req_in`=1101 (owner silent) → `grant_out`=0 and `valid_out`=0 the next cycle; the lock remains.
- **Credits:** BUF_DEPTH=2, continuous requests, `credit_in` pulsed together with a grant → `cred_r` unchanged. When `cred_r`=0, a `credit_in` at edge t → grant in cycle t+1.
- **Reset mid-packet:** assert `rst_n`=0 after a HEAD grant → the same cycle `avail_out`=1, `valid_out`=0, `cred_r`=BUF_DEPTH; after release, a new head from another input is granted.

Source files
------------

// File: rtl/rtr_out_alloc.sv
// Per-output switch allocator: round-robin grant, wormhole lock from head to tail,
// downstream credit tracking and a registered output flit stage.
//
// lock state | meaning
// LK_FREE    | output not owned; any requesting input may win
// LK_LOCKED  | output owned by owner_r until its tail flit is granted
module rtr_out_alloc #(
   parameter int IN_PORTS   = 4,
   parameter int FLIT_WIDTH = 16,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [IN_PORTS-1:0]              req_in,
   input  logic [IN_PORTS*FLIT_WIDTH-1:0]   data_in,
   output logic [IN_PORTS-1:0]              grant_out,
   output logic                             avail_out,
   output logic                             ready_out,
   output logic                             valid_out,
   output logic [FLIT_WIDTH-1:0]            data_out,
   input  logic                             credit_in
);

   localparam int IW = (IN_PORTS > 1) ? $clog2(IN_PORTS) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);

   localparam logic [1:0] FT_BODY   = 2'b00;
   localparam logic [1:0] FT_HEAD   = 2'b01;
   localparam logic [1:0] FT_TAIL   = 2'b10;
   localparam logic [1:0] FT_SINGLE = 2'b11;

   localparam logic [0:0] LK_FREE   = 1'b0;
   localparam logic [0:0] LK_LOCKED = 1'b1;

   localparam logic [CW-1:0] CRED_MAX = CW'(BUF_DEPTH);
   localparam logic [IW-1:0] LAST     = IW'(IN_PORTS - 1);

   logic [0:0]            lock_r;
   logic [IW-1:0]         owner_r;
   logic [IW-1:0]         ptr_r;
   logic [CW-1:0]         cred_r;

   logic [IN_PORTS-1:0]   elig;
   logic                  found;
   logic [IW-1:0]         win;
   logic [FLIT_WIDTH-1:0] flit_w;

   // Masking is done here so a misbehaving input cannot steal a locked output
   // or overrun the downstream buffer; reset also forces the grant low.
   always_comb begin
      elig = req_in;
      if (lock_r == LK_LOCKED) elig = req_in & (IN_PORTS'(1) << owner_r);
      if (cred_r == '0 || !rst_n) elig = '0;
   end

   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < IN_PORTS; k++) begin
         if (!found && elig[(int'(ptr_r) + k) % IN_PORTS]) begin
            found = 1'b1;
            win   = IW'((int'(ptr_r) + k) % IN_PORTS);
         end
      end
   end

   assign flit_w    = data_in[int'(win)*FLIT_WIDTH +: FLIT_WIDTH];
   assign grant_out = found ? (IN_PORTS'(1) << win) : '0;
   assign avail_out = (lock_r == LK_FREE);
   assign ready_out = (cred_r != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_r    <= LK_FREE;
         owner_r   <= '0;
         ptr_r     <= '0;
         cred_r    <= CRED_MAX;
         valid_out <= 1'b0;
         data_out  <= '0;
      end else begin
         if (found) begin
            ptr_r     <= (win == LAST) ? '0 : win + 1'b1;
            valid_out <= 1'b1;
            data_out  <= flit_w;
            case (flit_w[1:0])
               FT_HEAD: begin
                  lock_r  <= LK_LOCKED;
                  owner_r <= win;
               end
               FT_TAIL, FT_SINGLE: lock_r <= LK_FREE;
               FT_BODY:            lock_r <= lock_r;
               default:            lock_r <= lock_r;
            endcase
         end else begin
            valid_out <= 1'b0;
         end

         if (found && !credit_in)
            cred_r <= cred_r - 1'b1;
         else if (!found && credit_in && cred_r != CRED_MAX)
            cred_r <= cred_r + 1'b1;
      end
   end

   always @(posedge clk) begin
      if (rst_n) begin
         assert ($onehot0(grant_out)) else $fatal(1, "grant_out is not one-hot or zero");
         assert (!(found && cred_r == '0)) else $fatal(1, "grant issued with no credit");
         assert (!(found && $isunknown(flit_w[1:0]))) else $fatal(1, "granted flit type is unknown");
         assert (!(credit_in && !found && cred_r == CRED_MAX))
            else $fatal(1, "credit returned while credit counter full");
      end
   end

endmodule

// File: tb/tb_rtr_out_alloc.sv
// Bench for rtr_out_alloc: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model of the allocation rules.
module tb_rtr_out_alloc;

   localparam int NP = 4;
   localparam int FW = 16;
   localparam int BD = 4;

   localparam logic [1:0] BODY = 2'b00;
   localparam logic [1:0] HEAD = 2'b01;
   localparam logic [1:0] TAIL = 2'b10;
   localparam logic [1:0] SNGL = 2'b11;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [NP-1:0]     req_in = '0;
   logic [NP*FW-1:0]  data_in = '0;
   logic [NP-1:0]     grant_out;
   logic              avail_out, ready_out, valid_out;
   logic [FW-1:0]     data_out;
   logic              credit_in = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   bit            m_lock;
   int            m_owner, m_ptr, m_cred;
   bit            m_valid;
   logic [FW-1:0] m_data;
   logic [FW-1:0] fl [NP];
   logic [NP-1:0] g;

   rtr_out_alloc #(.IN_PORTS(NP), .FLIT_WIDTH(FW), .BUF_DEPTH(BD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_in    (req_in),
      .data_in   (data_in),
      .grant_out (grant_out),
      .avail_out (avail_out),
      .ready_out (ready_out),
      .valid_out (valid_out),
      .data_out  (data_out),
      .credit_in (credit_in)
   );

   always #5 clk = ~clk;

   function automatic logic [FW-1:0] mk(input logic [1:0] t);
      logic [FW-1:0] v;
      v = FW'($urandom);
      v[1:0] = t;
      return v;
   endfunction

   // Winner index under the allocation rules, or -1 when nothing may go.
   function automatic int pick(input logic [NP-1:0] req);
      if (m_cred == 0) return -1;
      for (int k = 0; k < NP; k++) begin
         int i;
         i = (m_ptr + k) % NP;
         if (req[i] && (!m_lock || i == m_owner)) return i;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_lock = 0; m_owner = 0; m_ptr = 0; m_cred = BD; m_valid = 0; m_data = '0;
   endtask

   // One clock cycle: drive at negedge, check before posedge, advance model.
   task automatic step(input logic [NP-1:0] req, input logic cr, output logic [NP-1:0] gnt);
      int w;
      logic [NP-1:0] eg;
      logic [1:0] t;
      req_in = req;
      for (int i = 0; i < NP; i++) data_in[i*FW +: FW] = fl[i];
      w = pick(req);
      credit_in = cr && !(w < 0 && m_cred == BD);
      eg = (w < 0) ? '0 : (NP'(1) << w);
      #1;
      chk("grant", 32'(grant_out), 32'(eg));
      chk("avail", 32'(avail_out), 32'(!m_lock));
      chk("ready", 32'(ready_out), 32'(m_cred != 0));
      chk("valid", 32'(valid_out), 32'(m_valid));
      chk("data",  32'(data_out),  32'(m_data));
      gnt = grant_out;
      @(posedge clk);
      if (w >= 0) begin
         t = fl[w][1:0];
         m_ptr = (w + 1) % NP;
         m_valid = 1;
         m_data = fl[w];
         m_cred = m_cred - 1;
         if (t == HEAD) begin
            m_lock = 1;
            m_owner = w;
         end else if (t == TAIL || t == SNGL) begin
            m_lock = 0;
         end
      end else begin
         m_valid = 0;
      end
      if (credit_in) m_cred = m_cred + 1;
      @(negedge clk);
      credit_in = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_grant", 32'(grant_out), 32'd0);
      chk("rst_avail", 32'(avail_out), 32'd1);
      chk("rst_ready", 32'(ready_out), 32'd1);
      chk("rst_valid", 32'(valid_out), 32'd0);
      @(negedge clk);
      req_in = '0;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < NP; i++) fl[i] = '0;
      #2;
      do_reset();
      chk("rst_data", 32'(data_out), 32'd0);

      // single flit from input 1
      fl[1] = mk(SNGL);
      step(4'b0010, 1'b0, g);
      chk("single_grant", 32'(g), 32'b0010);
      #1;
      chk("single_valid", 32'(valid_out), 32'd1);
      chk("single_data", 32'(data_out), 32'(fl[1]));
      chk("single_avail", 32'(avail_out), 32'd1);
      for (int i = 0; i < NP; i++) fl[i] = mk(SNGL);
      step(4'b1111, 1'b0, g);
      chk("single_ptr", 32'(g), 32'b0100);

      // round-robin from reset until credits run out
      do_reset();
      for (int i = 0; i < NP; i++) fl[i] = mk(SNGL);
      for (int k = 0; k < 4; k++) begin
         step(4'b1111, 1'b0, g);
         chk("rr_grant", 32'(g), 32'(4'b0001 << k));
      end
      #1;
      chk("rr_ready", 32'(ready_out), 32'd0);

      // credit return: credit at edge t lets a grant through in t+1
      step(4'b1111, 1'b1, g);
      chk("cred_nogrant", 32'(g), 32'd0);
      step(4'b1111, 1'b1, g);
      chk("cred_ret_grant", 32'(g), 32'b0001);
      step(4'b1111, 1'b0, g);
      chk("cred_both_same", 32'(g), 32'b0010);
      step(4'b1111, 1'b0, g);
      chk("cred_empty", 32'(g), 32'd0);

      // wormhole lock: input 0 sends a 3-flit packet while input 3 waits
      do_reset();
      fl[3] = mk(SNGL);
      fl[0] = mk(HEAD);
      step(4'b1001, 1'b0, g);
      chk("worm_head", 32'(g), 32'b0001);
      fl[0] = mk(BODY);
      step(4'b1001, 1'b0, g);
      chk("worm_body", 32'(g), 32'b0001);
      fl[0] = mk(TAIL);
      step(4'b1001, 1'b0, g);
      chk("worm_tail", 32'(g), 32'b0001);
      step(4'b1000, 1'b0, g);
      chk("worm_next", 32'(g), 32'b1000);
      #1;
      chk("worm_free", 32'(avail_out), 32'd1);

      // owner stall: locked to input 1, owner goes silent
      do_reset();
      fl[1] = mk(HEAD);
      step(4'b0010, 1'b0, g);
      for (int i = 0; i < NP; i++) fl[i] = mk(SNGL);
      step(4'b1101, 1'b0, g);
      chk("stall_grant", 32'(g), 32'd0);
      #1;
      chk("stall_valid", 32'(valid_out), 32'd0);
      chk("stall_lock", 32'(avail_out), 32'd0);

      // reset in the middle of a packet
      do_reset();
      fl[0] = mk(HEAD);
      step(4'b0001, 1'b0, g);
      req_in = 4'b0001;
      do_reset();
      fl[2] = mk(HEAD);
      step(4'b0100, 1'b0, g);
      chk("rst_mid_new", 32'(g), 32'b0100);

      // random traffic against the model
      do_reset();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NP; i++) fl[i] = mk(2'($urandom_range(0, 3)));
         step(NP'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), g);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
